ca3_theta_scheduler: RTL and testbench

- Theta-phase sequencer and two-port arbiter in front of ca3_phase_memory.
- Accepts learn/recall requests from two requesters and grants one at a time, round-robin.
- Learn requests drive the CA3 pattern input only during a fresh theta peak window; recall cues are driven only during a fresh theta trough window.
- Captures the recalled phase_pattern and returns it on a valid/ready response channel. Sits between the thalamic theta hopf_oscillator output and the CA3 block.

---
 rtl/ca3_theta_scheduler.sv | 177 +++++++++++++++++
 tb/tb_ca3_theta_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ca3_theta_scheduler.sv
// rtl/ca3_theta_scheduler.sv - theta-phase sequencer and round-robin arbiter in front of ca3_phase_memory
module ca3_theta_scheduler #(
    parameter int WIDTH       = 18,
    parameter int N_UNITS     = 6,
    parameter int PEAK_TH     = 12288,
    parameter int TROUGH_TH   = -12288,
    parameter int HYST        = 4096,
    parameter int LEARN_HOLD  = 50,
    parameter int RECALL_HOLD = 20,
    parameter int TIMEOUT     = 2000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic [WIDTH-1:0]       theta_x,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_mode,
    input  logic [2*N_UNITS-1:0]   req_pattern,
    output logic [1:0]             req_ready,
    output logic [N_UNITS-1:0]     mem_pattern,
    input  logic [N_UNITS-1:0]     mem_phase_pattern,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic                   rsp_err,
    output logic [N_UNITS-1:0]     rsp_pattern,
    output logic                   busy,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_PEAK   = 3'd1,
        LEARN       = 3'd2,
        WAIT_TROUGH = 3'd3,
        RECALL      = 3'd4,
        RESPOND     = 3'd5
    } state_t;

    // One counter serves both the window wait and the pattern hold.
    localparam int HOLD_MAX = (LEARN_HOLD > RECALL_HOLD) ? LEARN_HOLD : RECALL_HOLD;
    localparam int CNT_MAX  = (TIMEOUT > HOLD_MAX) ? TIMEOUT : HOLD_MAX;
    localparam int CW       = $clog2(CNT_MAX + 1);

    localparam logic signed [WIDTH-1:0] PEAK_ENTER   = WIDTH'(PEAK_TH);
    localparam logic signed [WIDTH-1:0] PEAK_EXIT    = WIDTH'(PEAK_TH - HYST);
    localparam logic signed [WIDTH-1:0] TROUGH_ENTER = WIDTH'(TROUGH_TH);
    localparam logic signed [WIDTH-1:0] TROUGH_EXIT  = WIDTH'(TROUGH_TH + HYST);

    state_t               state, state_n;
    logic                 in_peak, in_trough;
    logic                 peak_next, trough_next;
    logic                 peak_evt, trough_evt;
    logic                 rr_ptr, rr_n;
    logic                 lat_id, id_n;
    logic [N_UNITS-1:0]   lat_pattern, pat_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [N_UNITS-1:0]   mem_n, rp_n;
    logic                 rv_n, re_n;
    logic                 grant_id;
    logic signed [WIDTH-1:0] theta_s;

    assign theta_s   = theta_x;
    assign rsp_id    = lat_id;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Hysteretic window flags; an event is the rising edge of a flag on an update.
    always_comb begin
        peak_next   = in_peak   ? (theta_s >= PEAK_EXIT)   : (theta_s >= PEAK_ENTER);
        trough_next = in_trough ? (theta_s <= TROUGH_EXIT) : (theta_s <= TROUGH_ENTER);
        peak_evt    = clk_en & ~in_peak & peak_next;
        trough_evt  = clk_en & ~in_trough & trough_next;
        // A lone requester wins outright; a tie goes to rr_ptr.
        grant_id    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    end

    // Window flag registers advance only on clk_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_peak   <= 1'b0;
            in_trough <= 1'b0;
        end else if (clk_en) begin
            in_peak   <= peak_next;
            in_trough <= trough_next;
        end
    end

    // Next-state, datapath next values and the combinational accept pulse.
    always_comb begin
        state_n   = state;
        rr_n      = rr_ptr;
        id_n      = lat_id;
        pat_n     = lat_pattern;
        cnt_n     = cnt;
        mem_n     = mem_pattern;
        rv_n      = rsp_valid;
        re_n      = rsp_err;
        rp_n      = rsp_pattern;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    rr_n      = ~grant_id;
                    id_n      = grant_id;
                    pat_n     = grant_id ? req_pattern[2*N_UNITS-1:N_UNITS]
                                         : req_pattern[N_UNITS-1:0];
                    cnt_n     = '0;
                    state_n   = req_mode[grant_id] ? WAIT_TROUGH : WAIT_PEAK;
                end
            end
            WAIT_PEAK, WAIT_TROUGH: begin
                if (clk_en) begin
                    if ((state == WAIT_PEAK) ? peak_evt : trough_evt) begin
                        mem_n   = lat_pattern;
                        cnt_n   = CW'(1);
                        state_n = (state == WAIT_PEAK) ? LEARN : RECALL;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        re_n    = 1'b1;
                        rp_n    = '0;
                        rv_n    = 1'b1;
                        state_n = RESPOND;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            LEARN, RECALL: begin
                if (clk_en) begin
                    if (cnt == ((state == LEARN) ? CW'(LEARN_HOLD) : CW'(RECALL_HOLD))) begin
                        mem_n   = '0;
                        rp_n    = (state == LEARN) ? lat_pattern : mem_phase_pattern;
                        rv_n    = 1'b1;
                        state_n = RESPOND;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    rv_n    = 1'b0;
                    re_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            lat_id      <= 1'b0;
            lat_pattern <= '0;
            cnt         <= '0;
            mem_pattern <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_pattern <= '0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_n;
            lat_id      <= id_n;
            lat_pattern <= pat_n;
            cnt         <= cnt_n;
            mem_pattern <= mem_n;
            rsp_valid   <= rv_n;
            rsp_err     <= re_n;
            rsp_pattern <= rp_n;
        end
    end

endmodule

// File: tb/tb_ca3_theta_scheduler.sv
// tb/tb_ca3_theta_scheduler.sv - randomized self-checking bench for ca3_theta_scheduler
module tb_ca3_theta_scheduler;

    localparam int N           = 6;
    localparam int LEARN_HOLD  = 50;
    localparam int RECALL_HOLD = 20;
    localparam int TIMEOUT     = 2000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clk_en = 1'b0;
    logic [17:0]        theta_x = '0;
    logic [1:0]         req_valid = '0;
    logic [1:0]         req_mode = '0;
    logic [2*N-1:0]     req_pattern = '0;
    logic [1:0]         req_ready;
    logic [N-1:0]       mem_pattern;
    logic [N-1:0]       mem_phase_pattern = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic               rsp_id;
    logic               rsp_err;
    logic [N-1:0]       rsp_pattern;
    logic               busy;
    logic [2:0]         state_dbg;

    ca3_theta_scheduler dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .theta_x(theta_x),
        .req_valid(req_valid), .req_mode(req_mode), .req_pattern(req_pattern),
        .req_ready(req_ready), .mem_pattern(mem_pattern),
        .mem_phase_pattern(mem_phase_pattern), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_pattern(rsp_pattern), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state: theta generator, window flags, round-robin pointer.
    int       th = 0;
    int       th_dir = 1;
    int       th_step = 500;
    bit       th_move = 1'b0;
    bit       m_peak = 1'b0;
    bit       m_trough = 1'b0;
    bit       m_rr = 1'b0;
    bit       evt_p, evt_t;
    logic [N-1:0] last_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the reference window model.
    task automatic tick(input bit en);
        bit np, nt;
        clk_en            = en;
        theta_x           = 18'(th);
        mem_phase_pattern = N'($urandom);
        last_phase        = mem_phase_pattern;
        @(posedge clk);
        evt_p = 1'b0;
        evt_t = 1'b0;
        if (en) begin
            np = m_peak   ? (th >= 8192)   : (th >= 12288);
            nt = m_trough ? (th <= -8192)  : (th <= -12288);
            evt_p = np && !m_peak;
            evt_t = nt && !m_trough;
            m_peak   = np;
            m_trough = nt;
            if (th_move) begin
                th = th + th_dir * th_step;
                if (th > 16000)  begin th = 16000;  th_dir = -1; end
                if (th < -16000) begin th = -16000; th_dir = 1;  end
            end
        end
        #1;
    endtask

    function automatic bit rand_en();
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic run_txn(input logic [1:0] v, input logic [1:0] m, input logic [2*N-1:0] p,
                           input int stall_at, input int rst_at, input int rsp_wait);
        int g, upd, hold, cyc, n;
        bit mode, holding, done, stalled, exp_err;
        logic [N-1:0] pat, exp_rsp;
        logic [1:0] exp_rdy;
        logic [2*N-1:0] pv;
        g       = (v == 2'b11) ? int'(m_rr) : (v[1] ? 1 : 0);
        pv      = p;
        pat     = pv[g*N +: N];
        mode    = m[g];
        exp_rdy = (g == 1) ? 2'b10 : 2'b01;
        exp_err = 1'b0;
        exp_rsp = '0;
        req_valid = v; req_mode = m; req_pattern = p;
        #1;
        check("req_ready_grant", 32'(req_ready), 32'(exp_rdy));
        check("busy_idle", 32'(busy), 0);
        tick(rand_en());
        req_valid = 2'b00;
        m_rr = (g == 0);
        #1;
        check("req_ready_pulse", 32'(req_ready), 0);
        check("state_wait", 32'(state_dbg), mode ? 3 : 1);
        upd = 0; hold = 0; cyc = 0; holding = 0; done = 0; stalled = 0;
        while (!done && cyc < 20000) begin
            if (holding && hold == stall_at && !stalled) begin
                stalled = 1'b1;
                repeat (100) begin
                    tick(1'b0);
                    check("mem_pattern_stall", 32'(mem_pattern), 32'(pat));
                end
                check("state_stall", 32'(state_dbg), mode ? 4 : 2);
            end
            if (holding && rst_at >= 0 && hold == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_mem_pattern", 32'(mem_pattern), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_rsp_valid", 32'(rsp_valid), 0);
                check("rst_state", 32'(state_dbg), 0);
                m_peak = 1'b0; m_trough = 1'b0; m_rr = 1'b0;
                tick(1'b0);
                rst_n = 1'b1;
                return;
            end
            tick(rand_en());
            cyc++;
            if (clk_en) begin
                if (!holding) begin
                    upd++;
                    if (mode ? evt_t : evt_p) begin
                        holding = 1'b1;
                        hold = 0;
                    end else if (upd == TIMEOUT) begin
                        done = 1'b1; exp_err = 1'b1; exp_rsp = '0;
                    end
                end else begin
                    hold++;
                    if (hold == (mode ? RECALL_HOLD : LEARN_HOLD)) begin
                        done = 1'b1; holding = 1'b0; exp_err = 1'b0;
                        exp_rsp = mode ? last_phase : pat;
                    end
                end
            end
            check("mem_pattern", 32'(mem_pattern), holding ? 32'(pat) : 0);
            if (!done) check("rsp_valid_early", 32'(rsp_valid), 0);
        end
        check("txn_done", 32'(done), 1);
        n = (rsp_wait >= 0) ? rsp_wait : $urandom_range(0, 4);
        for (int i = 0; i <= n; i++) begin
            check("rsp_valid", 32'(rsp_valid), 1);
            check("rsp_id", 32'(rsp_id), 32'(g));
            check("rsp_err", 32'(rsp_err), 32'(exp_err));
            check("rsp_pattern", 32'(rsp_pattern), 32'(exp_rsp));
            check("mem_pattern_rsp", 32'(mem_pattern), 0);
            if (i < n) tick(rand_en());
        end
        rsp_ready = 1'b1;
        tick(rand_en());
        rsp_ready = 1'b0;
        check("rsp_valid_clear", 32'(rsp_valid), 0);
        check("rsp_err_clear", 32'(rsp_err), 0);
        check("busy_after_rsp", 32'(busy), 0);
    endtask

    initial begin
        #2;
        check("reset_mem_pattern", 32'(mem_pattern), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_err", 32'(rsp_err), 0);
        check("reset_rsp_pattern", 32'(rsp_pattern), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_state", 32'(state_dbg), 0);
        tick(1'b0);
        tick(1'b0);
        rst_n = 1'b1;
        tick(1'b0);

        // Learn on requester 0 with theta rising through the peak threshold.
        th = -16000; th_dir = 1; th_step = 400; th_move = 1'b1;
        run_txn(2'b01, 2'b00, {6'b000000, 6'b101010}, -1, -1, -1);

        // Recall on requester 1 granted while already inside the trough.
        th_move = 1'b0; th = -13000;
        repeat (3) tick(1'b1);
        th_dir = 1; th_step = 500; th_move = 1'b1;
        run_txn(2'b10, 2'b10, {6'b100000, 6'b000000}, -1, -1, -1);

        // Learn with a 100-cycle clk_en stall in the middle of the hold.
        run_txn(2'b01, 2'b00, {6'b000000, 6'b110011}, 10, -1, -1);

        // Theta parked at zero: window timeout.
        th_move = 1'b0; th = 0;
        run_txn(2'b10, 2'b00, {6'b011101, 6'b000000}, -1, -1, 2);

        // Reset in the middle of a learn hold.
        th = -16000; th_dir = 1; th_step = 600; th_move = 1'b1;
        run_txn(2'b01, 2'b00, {6'b000000, 6'b111111}, -1, 5, -1);

        // Both requesters valid twice in a row after reset, response held off.
        run_txn(2'b11, 2'b00, {6'b000111, 6'b111000}, -1, -1, 10);
        run_txn(2'b11, 2'b11, {6'b010101, 6'b001100}, -1, -1, 10);

        // Randomized mix.
        for (int k = 0; k < 12; k++) begin
            logic [1:0] rv;
            rv = 2'($urandom_range(1, 3));
            th_step = $urandom_range(300, 900);
            run_txn(rv, 2'($urandom), 12'($urandom), -1, -1, -1);
            repeat ($urandom_range(0, 3)) tick(rand_en());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
